// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM-port responder: bus widths and the
// state / command encodings used by the control FSM.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_BE_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STALL  = 3'd1,
    R_LAT  = 3'd2,
    R_RESP = 3'd3,
    W_ACK  = 3'd4
  } state_e;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

endpackage

// File: rtl/sdram_word_ram.sv
// Single-port, synchronous-read word RAM with active-low byte enables.
// Read-during-write returns the old word; contents are not reset.
module sdram_word_ram
  import sdram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                    clk,
  input  logic [AW-1:0]           addr,
  input  logic                    we,
  input  logic [SDRAM_BE_W-1:0]   be_n,
  input  logic [SDRAM_DATA_W-1:0] wdata,
  output logic [SDRAM_DATA_W-1:0] rdata
);

  logic [SDRAM_DATA_W-1:0] mem [0:(1<<AW)-1];
  logic [SDRAM_DATA_W-1:0] rdata_q;

  // Byte-masked write and registered read on the same address port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SDRAM_BE_W; i++) begin
        if (!be_n[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// Avalon-style responder for the SDRAM master port. One transaction at a
// time: a command is latched in IDLE, stalled for WAIT_CYCLES, then either
// acknowledged as a write or returned as a read after READ_LATENCY more
// cycles. Handshake: wait_req stays 1 until the single completion cycle
// (R_RESP or W_ACK); valid is 1 only in R_RESP; the master holds its strobe
// and command until it sees that cycle. wait_req/valid decode the state
// register only, so no input reaches an output combinationally.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    read_n,
  input  logic                    write_n,
  input  logic [SDRAM_BE_W-1:0]   byte_enable_n,
  input  logic [SDRAM_ADDR_W-1:0] address,
  input  logic [SDRAM_DATA_W-1:0] write_data,
  output logic [SDRAM_DATA_W-1:0] read_data,
  output logic                    valid,
  output logic                    wait_req,
  output logic                    err
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [3:0] LAT_LD  = 4'(READ_LATENCY);
  // Phase a read enters once its stall is over.
  localparam state_e RD_PHASE = (READ_LATENCY == 0) ? R_RESP : R_LAT;

  state_e                  state_q, state_d;
  cmd_e                    cmd_q, cmd_d;
  logic [MEM_AW-1:0]       addr_q, addr_d;
  logic [SDRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [SDRAM_BE_W-1:0]   be_n_q, be_n_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [SDRAM_DATA_W-1:0] hold_q, hold_d;

  logic [MEM_AW-1:0]       ram_addr;
  logic                    ram_we;
  logic [SDRAM_DATA_W-1:0] ram_rdata;
  logic                    strobe_off;
  logic                    unused_addr_hi;

  // Upper address bits are deliberately ignored so addresses alias.
  assign unused_addr_hi = ^address[SDRAM_ADDR_W-1:MEM_AW];

  // The strobe that started the transaction; its release means abort.
  assign strobe_off = (cmd_q == CMD_READ) ? read_n : write_n;

  // In IDLE the RAM looks at the live address so a zero-latency read has
  // data in R_RESP; otherwise the latched address is used.
  assign ram_addr = (state_q == IDLE) ? address[MEM_AW-1:0] : addr_q;
  assign ram_we   = (state_q == W_ACK);

  sdram_word_ram #(.AW(MEM_AW)) u_ram (
    .clk   (Clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be_n  (be_n_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state, counter and command-latch logic.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_n_d  = be_n_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (!read_n || !write_n) begin
          cmd_d   = (!read_n) ? CMD_READ : CMD_WRITE;
          addr_d  = address[MEM_AW-1:0];
          wdata_d = write_data;
          be_n_d  = byte_enable_n;
          if (!read_n && !write_n) begin
            err_d = 1'b1;
          end
          if (WAIT_CYCLES != 0) begin
            state_d = STALL;
            cnt_d   = WAIT_LD;
          end else if (!read_n) begin
            state_d = RD_PHASE;
            cnt_d   = LAT_LD;
          end else begin
            state_d = W_ACK;
          end
        end
      end
      STALL: begin
        if (strobe_off) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) begin
            if (cmd_q == CMD_WRITE) begin
              state_d = W_ACK;
            end else begin
              state_d = RD_PHASE;
              cnt_d   = LAT_LD;
            end
          end
        end
      end
      R_LAT: begin
        if (strobe_off) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) begin
            state_d = R_RESP;
          end
        end
      end
      R_RESP: begin
        hold_d  = ram_rdata;
        state_d = IDLE;
      end
      W_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      be_n_q  <= '1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_n_q  <= be_n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign valid     = (state_q == R_RESP);
  assign wait_req  = !((state_q == R_RESP) || (state_q == W_ACK));
  assign read_data = (state_q == R_RESP) ? ram_rdata : hold_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed cases from the test plan followed by
// random reads/writes, all checked against a word-array memory model and
// the cycle counts implied by WAIT_CYCLES / READ_LATENCY.
module tb_sdram_responder;

  localparam int AW = 10;
  localparam int W  = 1;
  localparam int L  = 2;

  logic        clk;
  logic        rst_n;
  logic        read_n;
  logic        write_n;
  logic [3:0]  byte_enable_n;
  logic [24:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        valid;
  logic        wait_req;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain word array plus a "written" flag per word.
  logic [31:0] ref_mem   [1<<AW];
  bit          ref_known [1<<AW];
  logic [31:0] exp_q[$];

  sdram_responder #(
    .MEM_AW       (AW),
    .WAIT_CYCLES  (W),
    .READ_LATENCY (L)
  ) dut (
    .Clk           (clk),
    .Reset         (rst_n),
    .read_n        (read_n),
    .write_n       (write_n),
    .byte_enable_n (byte_enable_n),
    .address       (address),
    .write_data    (write_data),
    .read_data     (read_data),
    .valid         (valid),
    .wait_req      (wait_req),
    .err           (err)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (!ben[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [24:0] a, input logic [31:0] d, input logic [3:0] ben);
    int k;
    logic [AW-1:0] idx;
    idx = a[AW-1:0];
    @(negedge clk);
    address = a; write_data = d; byte_enable_n = ben; write_n = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      address = 25'($urandom); write_data = $urandom; byte_enable_n = 4'($urandom);
    end while (wait_req && k < 40);
    chk("wr_ack_cycle", k, W + 1);
    chk("wr_no_valid", valid, 1'b0);
    write_n = 1'b1;
    ref_mem[idx]   = merge(ref_mem[idx], d, ben);
    ref_known[idx] = ref_known[idx] || (ben == 4'b0000);
    @(negedge clk);
    chk("wr_ack_once", wait_req, 1'b1);
  endtask

  task automatic do_read(input logic [24:0] a, input bit both, output logic [31:0] got);
    int k;
    logic [31:0] e;
    e = ref_mem[a[AW-1:0]];
    exp_q.push_back(e);
    @(negedge clk);
    address = a; read_n = 1'b0;
    if (both) begin
      write_n = 1'b0; write_data = ~e; byte_enable_n = 4'b0000;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      address = 25'($urandom); write_data = $urandom;
    end while (!valid && k < 40);
    chk("rd_valid_cycle", k, W + L + 1);
    chk("rd_wait_low", wait_req, 1'b0);
    got = read_data;
    chk("rd_data", got, exp_q.pop_front());
    read_n = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chk("rd_valid_once", {30'd0, wait_req, valid}, 32'd2);
    chk("rd_hold", read_data, e);
  endtask

  initial begin
    logic [31:0] got;
    int nv;
    for (int i = 0; i < (1<<AW); i++) begin
      ref_mem[i] = '0; ref_known[i] = 1'b0;
    end
    rst_n = 1'b0; read_n = 1'b1; write_n = 1'b1;
    byte_enable_n = 4'hF; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {28'd0, wait_req, valid, err, |read_data}, 32'b1000);
    rst_n = 1'b1;

    // Idle strobes after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {29'd0, wait_req, valid, err}, 32'b100);
    end

    // Full write then read-back.
    do_write(25'h0000010, 32'hDEADBEEF, 4'b0000);
    do_read(25'h0000010, 1'b0, got);
    chk("dir_deadbeef", got, 32'hDEADBEEF);

    // Partial byte-enable write.
    do_write(25'h0000020, 32'hAAAAAAAA, 4'b0000);
    do_write(25'h0000020, 32'h11223344, 4'b1010);
    do_read(25'h0000020, 1'b0, got);
    chk("dir_byte_en", got, 32'hAA22AA44);

    // Address aliasing above MEM_AW.
    do_write(25'h0000400, 32'h00000005, 4'b0000);
    do_read(25'h0000000, 1'b0, got);
    chk("dir_alias", got, 32'h00000005);

    // Both strobes low: served as a read, flagged, no write.
    do_read(25'h0000010, 1'b1, got);
    chk("both_err", err, 1'b1);
    repeat (5) @(negedge clk);
    chk("both_err_sticky", err, 1'b1);
    do_read(25'h0000010, 1'b0, got);
    chk("both_no_write", got, 32'hDEADBEEF);
    pulse_reset();
    @(negedge clk);
    chk("err_cleared", err, 1'b0);

    // Read strobe released during R_LAT: abort.
    @(negedge clk);
    address = 25'h0000020; read_n = 1'b0;
    repeat (W + 1) @(negedge clk);
    read_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_err", err, 1'b1);
    chk("abort_idle", wait_req, 1'b1);
    pulse_reset();

    // Reset during the STALL of a write: write is dropped.
    @(negedge clk);
    address = 25'h0000020; write_data = 32'h55555555; byte_enable_n = 4'b0000; write_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {28'd0, wait_req, valid, err, |read_data}, 32'b1000);
    @(negedge clk);
    write_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(25'h0000020, 1'b0, got);
    chk("rst_mid_unchanged", got, 32'hAA22AA44);

    // Random traffic over a small, fully initialised window.
    for (int i = 0; i < 16; i++) begin
      do_write({15'($urandom), 10'(i)}, $urandom, 4'b0000);
    end
    for (int n = 0; n < 60; n++) begin
      logic [24:0] a;
      a = {15'($urandom), 10'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom));
      end else begin
        do_read(a, 1'b0, got);
      end
    end
    chk("final_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
